vga_sync_gen: RTL and testbench

//  Raster timing generator feeding the colour/pattern stage of VGA_TEST_TOP.

---
 rtl/vga_sync_gen.sv | 142 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator. A clock divider produces a pixel tick, and the
//   tick advances the horizontal and vertical position counters. All timing
//   outputs are registered on the same edge as the counters, so they always
//   describe the position currently shown on x_o/y_o.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous reset, active-low
//   en_i          run enable; low freezes divider, counters and levels
//   pix_tick_o    one-clk pulse; counters advance on the next rising edge
//   hsync_o       horizontal sync (asserted level = SYNC_POL)
//   vsync_o       vertical sync   (asserted level = SYNC_POL)
//   active_o      current position lies in the visible window
//   x_o           horizontal position, 0 .. H_TOTAL-1
//   y_o           vertical position,   0 .. V_TOTAL-1
//   line_start_o  one-clk pulse after the counters wrapped to x = 0
//   frame_start_o one-clk pulse after the counters wrapped to (0,0)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          pix_tick_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          active_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // Divider needs at least one bit even when CLK_DIV = 1 (it then stays 0).
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] X_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] Y_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;
  logic          tick_s;
  logic          x_wrap_s;
  logic          y_wrap_s;

  // Next-state logic: divider, position counters, levels and strobes.
  always_comb begin
    // rst_ni gating keeps the tick quiet during reset when CLK_DIV = 1.
    tick_s   = rst_ni & en_i & (div_q == DIV_LAST);
    x_wrap_s = (x_q == X_LAST);
    y_wrap_s = (y_q == Y_LAST);

    if (!en_i) begin
      div_d = div_q;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end

    if (tick_s) begin
      x_d = x_wrap_s ? '0 : x_q + HW'(1);
      if (x_wrap_s) begin
        y_d = y_wrap_s ? '0 : y_q + VW'(1);
      end else begin
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end

    // Levels are decoded from the next position so they line up with x_q/y_q.
    hsync_d  = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    active_d = (x_d < X_ACT) && (y_d < Y_ACT);
    line_d   = tick_s & x_wrap_s;
    frame_d  = tick_s & x_wrap_s & y_wrap_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b1;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign pix_tick_o    = tick_s;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign active_o      = active_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = line_q;
  assign frame_start_o = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default instance (640x480, CLK_DIV 4) ----------------
  logic       rst_d = 1'b1;
  logic       en_d  = 1'b1;
  logic       d_tick, d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_x;
  logic [9:0] d_y;

  vga_sync_gen u_dut (
    .clk_i(clk), .rst_ni(rst_d), .en_i(en_d), .pix_tick_o(d_tick),
    .hsync_o(d_hs), .vsync_o(d_vs), .active_o(d_act), .x_o(d_x), .y_o(d_y),
    .line_start_o(d_ls), .frame_start_o(d_fs)
  );

  // ---------------- small instance (H 8/2/2/2, V 6/1/1/1, CLK_DIV 2) -----
  logic       rst_s = 1'b1;
  logic       en_s  = 1'b1;
  logic       s_tick, s_hs, s_vs, s_act, s_ls, s_fs;
  logic [3:0] s_x;
  logic [3:0] s_y;

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk_i(clk), .rst_ni(rst_s), .en_i(en_s), .pix_tick_o(s_tick),
    .hsync_o(s_hs), .vsync_o(s_vs), .active_o(s_act), .x_o(s_x), .y_o(s_y),
    .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Position after e enabled clocks: pixels elapsed = e / cd, then raster math.
  function automatic exp_t model_pos(input longint e, input int cd,
                                     input int ha, input int hfp, input int hs, input int hbp,
                                     input int va, input int vfp, input int vs, input int vbp,
                                     input bit pol);
    exp_t   r;
    longint n, x, y;
    int     ht, vt;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    n  = e / cd;
    x  = n % ht;
    y  = (n / ht) % vt;
    r.x   = 32'(x);
    r.y   = 32'(y);
    r.hs  = (x >= ha + hfp && x < ha + hfp + hs) ? pol : ~pol;
    r.vs  = (y >= va + vfp && y < va + vfp + vs) ? pol : ~pol;
    r.act = (x < ha) && (y < va);
    return r;
  endfunction

  // Reference: count of enabled clock edges since reset, plus strobe flags.
  longint e_d = 0, e_s = 0;
  logic   ls_dm = 1'b0, fs_dm = 1'b0, ls_sm = 1'b0, fs_sm = 1'b0;

  always @(posedge clk or negedge rst_d) begin
    if (!rst_d) begin
      e_d <= 0; ls_dm <= 1'b0; fs_dm <= 1'b0;
    end else begin
      e_d   <= e_d + (en_d ? 1 : 0);
      ls_dm <= en_d && ((e_d + 1) % 4 == 0) && (((e_d + 1) / 4) % 800 == 0);
      fs_dm <= en_d && ((e_d + 1) % 4 == 0) && (((e_d + 1) / 4) % (800 * 525) == 0);
    end
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      e_s <= 0; ls_sm <= 1'b0; fs_sm <= 1'b0;
    end else begin
      e_s   <= e_s + (en_s ? 1 : 0);
      ls_sm <= en_s && ((e_s + 1) % 2 == 0) && (((e_s + 1) / 2) % 14 == 0);
      fs_sm <= en_s && ((e_s + 1) % 2 == 0) && (((e_s + 1) / 2) % (14 * 9) == 0);
    end
  end

  exp_t rd, rs;

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    #2;
    rd = model_pos(e_d, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    chk("d_x", 32'(d_x), rd.x);
    chk("d_y", 32'(d_y), rd.y);
    chk("d_hsync", 32'(d_hs), 32'(rd.hs));
    chk("d_vsync", 32'(d_vs), 32'(rd.vs));
    chk("d_active", 32'(d_act), 32'(rd.act));
    chk("d_tick", 32'(d_tick), 32'(rst_d && en_d && (e_d % 4 == 3)));
    chk("d_line", 32'(d_ls), 32'(ls_dm));
    chk("d_frame", 32'(d_fs), 32'(fs_dm));
    rs = model_pos(e_s, 2, 8, 2, 2, 2, 6, 1, 1, 1, 1'b0);
    chk("s_x", 32'(s_x), rs.x);
    chk("s_y", 32'(s_y), rs.y);
    chk("s_hsync", 32'(s_hs), 32'(rs.hs));
    chk("s_vsync", 32'(s_vs), 32'(rs.vs));
    chk("s_active", 32'(s_act), 32'(rs.act));
    chk("s_tick", 32'(s_tick), 32'(rst_s && en_s && (e_s % 2 == 1)));
    chk("s_line", 32'(s_ls), 32'(ls_sm));
    chk("s_frame", 32'(s_fs), 32'(fs_sm));
  end

  task automatic chk_reset_d(input string tag);
    chk({tag, "_x"}, 32'(d_x), 32'd0);
    chk({tag, "_y"}, 32'(d_y), 32'd0);
    chk({tag, "_hs"}, 32'(d_hs), 32'd1);
    chk({tag, "_vs"}, 32'(d_vs), 32'd1);
    chk({tag, "_act"}, 32'(d_act), 32'd1);
    chk({tag, "_strobe"}, 32'({d_ls, d_fs, d_tick}), 32'd0);
  endtask

  task automatic chk_reset_s(input string tag);
    chk({tag, "_x"}, 32'(s_x), 32'd0);
    chk({tag, "_y"}, 32'(s_y), 32'd0);
    chk({tag, "_hs"}, 32'(s_hs), 32'd1);
    chk({tag, "_vs"}, 32'(s_vs), 32'd1);
    chk({tag, "_act"}, 32'(s_act), 32'd1);
    chk({tag, "_strobe"}, 32'({s_ls, s_fs, s_tick}), 32'd0);
  endtask

  initial begin
    #1;
    rst_d = 1'b0;
    rst_s = 1'b0;
    #29;
    chk_reset_d("d_rst");
    chk_reset_s("s_rst");
    @(negedge clk);
    rst_d = 1'b1;
    rst_s = 1'b1;

    fork
      // Directed line timing, enable stall and mid-line reset on the default instance.
      begin
        int k, c0;
        k = 0;
        while (d_hs !== 1'b0 && k < 6000) begin @(posedge clk); #1; k++; end
        chk("hs_fall_clks", 32'(k), 32'd2624);
        k = 0;
        while (d_hs === 1'b0 && k < 1000) begin @(posedge clk); #1; k++; end
        chk("hs_low_clks", 32'(k), 32'd384);
        k = 0;
        while (d_ls !== 1'b1 && k < 4000) begin @(posedge clk); #1; k++; end
        chk("ls_seen", 32'(d_ls), 32'd1);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (d_ls !== 1'b1 && k < 5000);
        chk("ls_period", 32'(k), 32'd3200);
        c0 = cyc;
        @(negedge clk);
        en_d = 1'b0;
        repeat (37) @(negedge clk);
        en_d = 1'b1;
        k = 0;
        while (d_hs !== 1'b0 && k < 6000) begin @(posedge clk); #1; k++; end
        chk("hs_shift", 32'(cyc - c0), 32'd2661);
        k = 0;
        while (d_x !== 10'd700 && k < 4000) begin @(posedge clk); #1; k++; end
        chk("x700_seen", 32'(d_x), 32'd700);
        #3;
        rst_d = 1'b0;
        #1;
        chk_reset_d("d_arst");
        @(negedge clk);
        rst_d = 1'b1;
        k = 0;
        while (d_x !== 10'd1 && k < 20) begin @(posedge clk); #1; k++; end
        chk("arst_first_tick", 32'(k), 32'd4);
        chk("arst_y", 32'(d_y), 32'd0);
        repeat (10) @(negedge clk);
      end
      // Randomised enable and occasional resets on the small instance, then frame period.
      begin
        int k;
        for (int i = 0; i < 4000; i++) begin
          @(negedge clk);
          en_s = ($urandom_range(0, 7) != 0);
          if (i == 2000 || $urandom_range(0, 799) == 0) begin
            #3;
            rst_s = 1'b0;
            #1;
            chk_reset_s("s_arst");
            @(negedge clk);
            rst_s = 1'b1;
          end
        end
        @(negedge clk);
        en_s = 1'b1;
        k = 0;
        while (s_fs !== 1'b1 && k < 600) begin @(posedge clk); #1; k++; end
        chk("fs_seen", 32'(s_fs), 32'd1);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (s_fs !== 1'b1 && k < 600);
        chk("fs_period", 32'(k), 32'd252);
        chk("fs_with_ls", 32'(s_ls), 32'd1);
      end
    join

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
